// File: rtl/peach_pkg.sv
// Shared types and widths for the Peach core memory path.
package peach_pkg;

    localparam int unsigned PEACH_XLEN   = 32;
    localparam int unsigned PEACH_STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    // A write with no enabled byte lanes completes without touching memory.
    function automatic logic is_zero_write(input logic we, input logic [PEACH_STRB_W-1:0] strb);
        return we && (strb == '0);
    endfunction

endpackage

// File: rtl/peach_rr_arb2.sv
// Two-way round-robin pick between fetch (I) and load/store (D) with the
// last-served register; grant is one-hot {D, I}.
module peach_rr_arb2
    import peach_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_valid_i,
    input  logic       i_valid_d,
    input  logic       i_enable,
    input  logic       i_update,
    input  logic       i_update_d,
    output logic [1:0] o_grant
);

    req_id_t r_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last <= REQ_D;
        end else if (i_update) begin
            r_last <= i_update_d ? REQ_D : REQ_I;
        end
    end

    // On a tie the requester not served last wins.
    always_comb begin
        o_grant = 2'b00;
        if (i_enable) begin
            if (i_valid_i && i_valid_d) begin
                o_grant = (r_last == REQ_D) ? 2'b01 : 2'b10;
            end else begin
                o_grant = {i_valid_d, i_valid_i};
            end
        end
    end

endmodule

// File: rtl/peach_mem_arbiter.sv
// Shares the single Peach memory port between instruction fetch and
// load/store: one transaction at a time, round-robin on ties, timeout abort.
module peach_mem_arbiter
    import peach_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = PEACH_XLEN,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req_valid,
    output logic                    i_req_ready,
    input  logic [ADDR_W-1:0]       i_req_addr,
    output logic                    i_rsp_valid,
    output logic [DATA_W-1:0]       i_rsp_data,
    output logic                    i_rsp_err,
    input  logic                    d_req_valid,
    output logic                    d_req_ready,
    input  logic [ADDR_W-1:0]       d_req_addr,
    input  logic                    d_req_we,
    input  logic [DATA_W-1:0]       d_req_wdata,
    input  logic [PEACH_STRB_W-1:0] d_req_wstrb,
    output logic                    d_rsp_valid,
    output logic [DATA_W-1:0]       d_rsp_data,
    output logic                    d_rsp_err,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [PEACH_STRB_W-1:0] mem_wstrb,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    busy
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_t              r_state;
    req_id_t                 r_id;
    logic                    r_zero;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_busy;
    logic                    r_mem_req;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic                    r_mem_we;
    logic [DATA_W-1:0]       r_mem_wdata;
    logic [PEACH_STRB_W-1:0] r_mem_wstrb;
    logic                    r_i_rsp_valid;
    logic [DATA_W-1:0]       r_i_rsp_data;
    logic                    r_i_rsp_err;
    logic                    r_d_rsp_valid;
    logic [DATA_W-1:0]       r_d_rsp_data;
    logic                    r_d_rsp_err;

    logic [1:0]              w_grant;
    logic                    w_idle;
    logic                    w_i_hs;
    logic                    w_d_hs;
    logic                    w_d_zero;
    logic                    w_timeout;
    logic                    w_fin;
    logic [DATA_W-1:0]       w_fin_data;
    logic                    w_fin_err;

    assign w_idle    = reset && (r_state == IDLE);
    assign w_i_hs    = i_req_valid && w_grant[0];
    assign w_d_hs    = d_req_valid && w_grant[1];
    assign w_d_zero  = is_zero_write(d_req_we, d_req_wstrb);
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT));

    peach_rr_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .i_valid_i  (i_req_valid),
        .i_valid_d  (d_req_valid),
        .i_enable   (w_idle),
        .i_update   (r_state == RESP),
        .i_update_d (r_id == REQ_D),
        .o_grant    (w_grant)
    );

    // Completion of the BUSY phase; an ack beats a coincident timeout.
    always_comb begin
        w_fin      = 1'b0;
        w_fin_data = '0;
        w_fin_err  = 1'b0;
        if (r_state == BUSY) begin
            if (r_zero) begin
                w_fin = 1'b1;
            end else if (mem_ack) begin
                w_fin      = 1'b1;
                w_fin_data = r_mem_we ? '0 : mem_rdata;
            end else if (w_timeout) begin
                w_fin     = 1'b1;
                w_fin_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_id          <= REQ_I;
            r_zero        <= 1'b0;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_we      <= 1'b0;
            r_mem_wdata   <= '0;
            r_mem_wstrb   <= '0;
            r_i_rsp_valid <= 1'b0;
            r_i_rsp_data  <= '0;
            r_i_rsp_err   <= 1'b0;
            r_d_rsp_valid <= 1'b0;
            r_d_rsp_data  <= '0;
            r_d_rsp_err   <= 1'b0;
        end else begin
            r_i_rsp_valid <= 1'b0;
            r_d_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_d_hs) begin
                        r_state     <= BUSY;
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                        r_id        <= REQ_D;
                        r_zero      <= w_d_zero;
                        r_mem_req   <= !w_d_zero;
                        r_mem_addr  <= d_req_addr;
                        r_mem_we    <= d_req_we;
                        r_mem_wdata <= d_req_wdata;
                        r_mem_wstrb <= d_req_wstrb;
                    end else if (w_i_hs) begin
                        r_state     <= BUSY;
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                        r_id        <= REQ_I;
                        r_zero      <= 1'b0;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= i_req_addr;
                        r_mem_we    <= 1'b0;
                        r_mem_wdata <= '0;
                        r_mem_wstrb <= '0;
                    end
                end
                BUSY: begin
                    if (w_fin) begin
                        r_state   <= RESP;
                        r_mem_req <= 1'b0;
                        if (r_id == REQ_D) begin
                            r_d_rsp_valid <= 1'b1;
                            r_d_rsp_data  <= w_fin_data;
                            r_d_rsp_err   <= w_fin_err;
                        end else begin
                            r_i_rsp_valid <= 1'b1;
                            r_i_rsp_data  <= w_fin_data;
                            r_i_rsp_err   <= w_fin_err;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign i_req_ready = w_grant[0];
    assign d_req_ready = w_grant[1];
    assign i_rsp_valid = r_i_rsp_valid;
    assign i_rsp_data  = r_i_rsp_data;
    assign i_rsp_err   = r_i_rsp_err;
    assign d_rsp_valid = r_d_rsp_valid;
    assign d_rsp_data  = r_d_rsp_data;
    assign d_rsp_err   = r_d_rsp_err;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign mem_we      = r_mem_we;
    assign mem_wdata   = r_mem_wdata;
    assign mem_wstrb   = r_mem_wstrb;
    assign busy        = r_busy;

endmodule

// File: tb/tb_peach_mem_arbiter.sv
// Scoreboard bench for peach_mem_arbiter: directed requests push expected
// responses, a negedge monitor pops and compares every response pulse.
module tb_peach_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req_valid;
    logic        i_req_ready;
    logic [31:0] i_req_addr;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;
    logic        i_rsp_err;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [31:0] d_req_addr;
    logic        d_req_we;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_wstrb;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        d_rsp_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          ack_delay = 0;
    logic        late_ack = 1'b0;
    logic        rd_ovr = 1'b0;
    logic [31:0] rd_val = 32'h0;
    int          req_run = 0;
    int          req_total = 0;
    int          base;

    peach_mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req_valid (i_req_valid),
        .i_req_ready (i_req_ready),
        .i_req_addr  (i_req_addr),
        .i_rsp_valid (i_rsp_valid),
        .i_rsp_data  (i_rsp_data),
        .i_rsp_err   (i_rsp_err),
        .d_req_valid (d_req_valid),
        .d_req_ready (d_req_ready),
        .d_req_addr  (d_req_addr),
        .d_req_we    (d_req_we),
        .d_req_wdata (d_req_wdata),
        .d_req_wstrb (d_req_wstrb),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_data  (d_rsp_data),
        .d_rsp_err   (d_rsp_err),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b, want %0b", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 30) begin
            tick();
            at_neg();
            n++;
        end
        chk_b(name, busy, 1'b0);
    endtask

    // Memory model: ack once mem_req has been high for more than ack_delay cycles.
    always @(posedge clk) begin
        #2;
        if (mem_req) begin
            req_run++;
            req_total++;
        end else begin
            req_run = 0;
        end
        mem_ack   = late_ack || (mem_req && ack_delay >= 0 && req_run > ack_delay);
        mem_rdata = rd_ovr ? rd_val : {16'hA5A5, mem_addr[15:0]};
    end

    always @(negedge clk) begin
        if (i_rsp_valid || d_rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rsp: got i_rsp_valid=%0b d_rsp_valid=%0b, want no response",
                         i_rsp_valid, d_rsp_valid);
            end else begin
                mon_e = exp_q.pop_front();
                chk_b("rsp_port_d", d_rsp_valid, mon_e.is_d);
                chk_b("rsp_port_i", i_rsp_valid, !mon_e.is_d);
                chk_w("rsp_data", mon_e.is_d ? d_rsp_data : i_rsp_data, mon_e.data);
                chk_b("rsp_err", mon_e.is_d ? d_rsp_err : i_rsp_err, mon_e.err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        i_req_valid = 1'b1;
        i_req_addr  = 32'h20;
        d_req_valid = 1'b1;
        d_req_addr  = 32'h200;
        d_req_we    = 1'b0;
        d_req_wdata = 32'h0;
        d_req_wstrb = 4'hF;
        ack_delay   = 0;

        // Reset state, ready held low while in reset.
        tick();
        tick();
        at_neg();
        chk_b("rst_i_ready", i_req_ready, 1'b0);
        chk_b("rst_d_ready", d_req_ready, 1'b0);
        chk_b("rst_mem_req", mem_req, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_i_rsp_valid", i_rsp_valid, 1'b0);
        chk_b("rst_d_rsp_valid", d_rsp_valid, 1'b0);
        chk_w("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk_w("rst_mem_addr", mem_addr, 32'h0);

        // Tie from the first IDLE after reset: I, D, I, D.
        tick();
        reset = 1'b1;
        at_neg();
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            while (!(i_req_ready || d_req_ready) && n < 20) begin
                tick();
                at_neg();
                n++;
            end
            chk_b($sformatf("tie%0d_i_ready", k), i_req_ready, (k % 2) == 0);
            chk_b($sformatf("tie%0d_d_ready", k), d_req_ready, (k % 2) == 1);
            if ((k % 2) == 0) exp_q.push_back({1'b0, 32'hA5A5_0020, 1'b0});
            else              exp_q.push_back({1'b1, 32'hA5A5_0200, 1'b0});
            tick();
            at_neg();
        end
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        wait_idle("tie_idle");

        // I only, ack in the first BUSY cycle.
        tick();
        rd_ovr      = 1'b1;
        rd_val      = 32'hDEAD_BEEF;
        i_req_valid = 1'b1;
        i_req_addr  = 32'h10;
        at_neg();
        chk_b("ionly_i_ready", i_req_ready, 1'b1);
        chk_b("ionly_d_ready", d_req_ready, 1'b0);
        exp_q.push_back({1'b0, 32'hDEAD_BEEF, 1'b0});
        tick();
        i_req_valid = 1'b0;
        at_neg();
        chk_b("ionly_mem_req", mem_req, 1'b1);
        chk_w("ionly_mem_addr", mem_addr, 32'h10);
        chk_b("ionly_mem_we", mem_we, 1'b0);
        chk_b("ionly_busy", busy, 1'b1);
        tick();
        at_neg();
        chk_b("ionly_rsp_n2", i_rsp_valid, 1'b1);
        chk_b("ionly_no_d_rsp", d_rsp_valid, 1'b0);
        tick();
        at_neg();
        chk_b("ionly_idle_n3", busy, 1'b0);
        rd_ovr = 1'b0;

        // D write with ack after 3 cycles.
        tick();
        ack_delay   = 2;
        d_req_valid = 1'b1;
        d_req_addr  = 32'h100;
        d_req_we    = 1'b1;
        d_req_wdata = 32'h1234_5678;
        d_req_wstrb = 4'b0011;
        at_neg();
        chk_b("dwr_d_ready", d_req_ready, 1'b1);
        exp_q.push_back({1'b1, 32'h0, 1'b0});
        tick();
        d_req_valid = 1'b0;
        d_req_we    = 1'b0;
        d_req_wstrb = 4'hF;
        for (int c = 1; c <= 3; c++) begin
            at_neg();
            chk_b($sformatf("dwr_mem_req_c%0d", c), mem_req, 1'b1);
            chk_b($sformatf("dwr_mem_we_c%0d", c), mem_we, 1'b1);
            chk_w($sformatf("dwr_mem_wstrb_c%0d", c), 32'(mem_wstrb), 32'h3);
            chk_w($sformatf("dwr_mem_wdata_c%0d", c), mem_wdata, 32'h1234_5678);
            tick();
        end
        at_neg();
        chk_b("dwr_rsp_valid", d_rsp_valid, 1'b1);
        chk_b("dwr_mem_req_drop", mem_req, 1'b0);
        wait_idle("dwr_idle");

        // Timeout with no ack; late acks must be ignored.
        tick();
        ack_delay   = -1;
        d_req_valid = 1'b1;
        d_req_addr  = 32'h300;
        at_neg();
        chk_b("to_d_ready", d_req_ready, 1'b1);
        exp_q.push_back({1'b1, 32'h0, 1'b1});
        base = req_total;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) d_req_valid = 1'b0;
            late_ack = (i == 6) || (i == 7);
            at_neg();
            if (i == 6) chk_b("to_rsp_n6", d_rsp_valid, 1'b1);
        end
        late_ack = 1'b0;
        chk_w("to_req_cycles", 32'(req_total - base), 32'd5);
        chk_b("to_idle", busy, 1'b0);

        // Zero-strobe write: no mem_req, response at N+2.
        tick();
        ack_delay   = 0;
        d_req_valid = 1'b1;
        d_req_addr  = 32'h400;
        d_req_we    = 1'b1;
        d_req_wdata = 32'h0000_FFFF;
        d_req_wstrb = 4'b0000;
        at_neg();
        chk_b("zw_d_ready", d_req_ready, 1'b1);
        exp_q.push_back({1'b1, 32'h0, 1'b0});
        base = req_total;
        tick();
        d_req_valid = 1'b0;
        d_req_we    = 1'b0;
        d_req_wstrb = 4'hF;
        at_neg();
        chk_b("zw_mem_req", mem_req, 1'b0);
        chk_b("zw_busy", busy, 1'b1);
        tick();
        at_neg();
        chk_b("zw_rsp_n2", d_rsp_valid, 1'b1);
        tick();
        at_neg();
        chk_b("zw_idle", busy, 1'b0);
        chk_w("zw_req_cycles", 32'(req_total - base), 32'd0);

        // Serve I so last_grant is I, then reset mid-BUSY and expect a tie to go to I.
        tick();
        i_req_valid = 1'b1;
        i_req_addr  = 32'h40;
        at_neg();
        chk_b("pre_i_ready", i_req_ready, 1'b1);
        exp_q.push_back({1'b0, 32'hA5A5_0040, 1'b0});
        tick();
        i_req_valid = 1'b0;
        at_neg();
        wait_idle("pre_idle");
        tick();
        ack_delay   = -1;
        i_req_valid = 1'b1;
        i_req_addr  = 32'h50;
        at_neg();
        chk_b("mr_i_ready", i_req_ready, 1'b1);
        tick();
        i_req_valid = 1'b0;
        at_neg();
        chk_b("mr_mem_req", mem_req, 1'b1);
        tick();
        reset       = 1'b0;
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        at_neg();
        chk_b("mr_in_rst_i_ready", i_req_ready, 1'b0);
        tick();
        reset       = 1'b1;
        i_req_addr  = 32'h60;
        d_req_addr  = 32'h200;
        ack_delay   = 0;
        at_neg();
        chk_b("mr_mem_req_cleared", mem_req, 1'b0);
        chk_b("mr_busy_cleared", busy, 1'b0);
        chk_b("mr_tie_i_ready", i_req_ready, 1'b1);
        chk_b("mr_tie_d_ready", d_req_ready, 1'b0);
        exp_q.push_back({1'b0, 32'hA5A5_0060, 1'b0});
        tick();
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        at_neg();
        wait_idle("mr_idle");

        repeat (4) begin
            tick();
            at_neg();
        end
        chk_w("pending_rsp", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
